mini_core_fetch: RTL

- Instruction-fetch front end of mini_core; produces the Q101H instruction stream consumed by the decode stage.
- Owns the PC, issues word requests to instruction memory over a valid/ready request channel, and buffers in-order responses in a 2-entry buffer.
- Honours the decode stall (PcEnQ101H) and branch/jump redirects from Q102H, discarding wrong-path responses.

---
 rtl/common_pkg.sv | 17 +
 rtl/mini_core_fetch_buf.sv | 55 +++++
 rtl/mini_core_fetch.sv | 129 ++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Types and constants shared between the mini_core fetch front end and decode.
package common_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } t_fetch_state;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } t_fetch_entry;

endpackage

// File: rtl/mini_core_fetch_buf.sv
// Two-entry in-order buffer of fetched {pc, inst} pairs feeding the Q101H stage.
module mini_core_fetch_buf
    import common_pkg::*;
(
    input  logic        Clock,
    input  logic        Rst,
    input  logic        push,
    input  logic [31:0] pushPc,
    input  logic [31:0] pushInst,
    input  logic        pop,
    input  logic        clear,
    output logic [31:0] headPc,
    output logic [31:0] headInst,
    output logic        full,
    output logic        empty,
    output logic [1:0]  count
);

    t_fetch_entry entryMem [2];
    logic         wrPtrReg;
    logic         rdPtrReg;
    logic [1:0]   countReg;
    logic         doPop;

    assign doPop = pop && (countReg != 2'd0);

    always_ff @(posedge Clock) begin
        if (push && Rst && !clear) begin
            entryMem[wrPtrReg] <= '{pc: pushPc, inst: pushInst};
        end
    end

    always_ff @(posedge Clock) begin
        if (!Rst || clear) begin
            wrPtrReg <= 1'b0;
            rdPtrReg <= 1'b0;
            countReg <= 2'd0;
        end else begin
            if (push) begin
                wrPtrReg <= ~wrPtrReg;
            end
            if (doPop) begin
                rdPtrReg <= ~rdPtrReg;
            end
            countReg <= countReg + 2'(push) - 2'(doPop);
        end
    end

    assign headPc   = entryMem[rdPtrReg].pc;
    assign headInst = entryMem[rdPtrReg].inst;
    assign full     = (countReg == 2'd2);
    assign empty    = (countReg == 2'd0);
    assign count    = countReg;

endmodule

// File: rtl/mini_core_fetch.sv
// Fetch front end: owns the PC, requests words from instruction memory with a
// two-credit limit, buffers in-order responses and drops wrong-path ones after a redirect.
module mini_core_fetch
    import common_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic        PcEnQ101H,
    input  logic        RedirectValidQ102H,
    input  logic [31:0] RedirectPcQ102H,
    output logic        IMemReqValid,
    input  logic        IMemReqReady,
    output logic [31:0] IMemReqAddr,
    input  logic        IMemRspValid,
    input  logic [31:0] IMemRspData,
    output logic [31:0] PreInstructionQ101H,
    output logic [31:0] PcQ101H,
    output logic        InstValidQ101H,
    output logic        MisalignRedirect
);

    t_fetch_state stateReg;
    logic [31:0]  pcQ100HReg;
    logic [31:0]  rspPcReg;
    logic [31:0]  lastPcReg;
    logic [1:0]   outstandingReg;
    logic [1:0]   outstandingNext;
    logic [1:0]   staleReg;
    logic         misalignReg;

    logic         reqValid;
    logic         reqFire;
    logic         rspTake;
    logic         bufPush;
    logic         bufPop;
    logic [31:0]  bufHeadPc;
    logic [31:0]  bufHeadInst;
    logic         bufFull;
    logic         bufEmpty;
    logic [1:0]   bufCount;
    logic [31:0]  redirectPc;

    // Credit covers both in-flight requests and buffered entries, so a push can never overflow.
    assign reqValid = (stateReg == S_RUN)
                    && ((3'(outstandingReg) + 3'(bufCount)) < 3'(BUF_DEPTH));
    assign reqFire  = reqValid && IMemReqReady;
    // With nothing outstanding a response can only belong to a pre-reset request.
    assign rspTake  = IMemRspValid && (outstandingReg != 2'd0);
    assign outstandingNext = outstandingReg + 2'(reqFire) - 2'(rspTake);

    assign bufPush    = (stateReg == S_RUN) && rspTake && !RedirectValidQ102H;
    assign bufPop     = PcEnQ101H && !bufEmpty && !RedirectValidQ102H;
    assign redirectPc = {RedirectPcQ102H[31:2], 2'b00};

    mini_core_fetch_buf u_buf (
        .Clock    (Clock),
        .Rst      (Rst),
        .push     (bufPush),
        .pushPc   (rspPcReg),
        .pushInst (IMemRspData),
        .pop      (bufPop),
        .clear    (RedirectValidQ102H),
        .headPc   (bufHeadPc),
        .headInst (bufHeadInst),
        .full     (bufFull),
        .empty    (bufEmpty),
        .count    (bufCount)
    );

    always_ff @(posedge Clock) begin
        if (!Rst) begin
            stateReg       <= S_IDLE;
            pcQ100HReg     <= RESET_PC;
            rspPcReg       <= RESET_PC;
            lastPcReg      <= RESET_PC;
            outstandingReg <= 2'd0;
            staleReg       <= 2'd0;
            misalignReg    <= 1'b0;
        end else begin
            outstandingReg <= outstandingNext;
            if (!bufEmpty) begin
                lastPcReg <= bufHeadPc;
            end
            if (RedirectValidQ102H) begin
                // A handshake this cycle was at the old PC, so it is counted as stale too.
                pcQ100HReg <= redirectPc;
                rspPcReg   <= redirectPc;
                staleReg   <= outstandingNext;
                stateReg   <= (outstandingNext != 2'd0) ? S_FLUSH : S_RUN;
                if (RedirectPcQ102H[1:0] != 2'b00) begin
                    misalignReg <= 1'b1;
                end
            end else begin
                if (reqFire) begin
                    pcQ100HReg <= pcQ100HReg + 32'd4;
                end
                if (bufPush) begin
                    rspPcReg <= rspPcReg + 32'd4;
                end
                case (stateReg)
                    S_IDLE:  stateReg <= S_RUN;
                    S_RUN:   stateReg <= S_RUN;
                    S_FLUSH: begin
                        if (rspTake) begin
                            staleReg <= staleReg - 2'd1;
                            if (staleReg == 2'd1) begin
                                stateReg <= S_RUN;
                            end
                        end
                    end
                    default: stateReg <= S_IDLE;
                endcase
            end
        end
    end

    assign IMemReqValid        = reqValid;
    assign IMemReqAddr         = pcQ100HReg;
    assign InstValidQ101H      = !bufEmpty;
    assign PreInstructionQ101H = bufEmpty ? NOP : bufHeadInst;
    assign PcQ101H             = bufEmpty ? lastPcReg : bufHeadPc;
    assign MisalignRedirect    = misalignReg;

    assert property (@(posedge Clock) disable iff (!Rst) !(bufPush && bufFull));

endmodule
